// File: rtl/avalon_mem_burst_splitter_if.sv
// Avalon-MM local-memory port bundle. One instance per side of the burst
// splitter; the two sides differ only in burstcount width.
interface avalon_mem_burst_splitter_if #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
);
  logic                       waitrequest;
  logic [DATA_WIDTH-1:0]      readdata;
  logic                       readdatavalid;
  logic [BURST_CNT_WIDTH-1:0] burstcount;
  logic [DATA_WIDTH-1:0]      writedata;
  logic [ADDR_WIDTH-1:0]      address;
  logic                       write;
  logic                       read;
  logic [DATA_WIDTH/8-1:0]    byteenable;

  // Requester side: issues reads/writes, receives stall and read data.
  modport master (
    input  waitrequest, readdata, readdatavalid,
    output burstcount, writedata, address, write, read, byteenable
  );

  // Responder side: accepts reads/writes, returns stall and read data.
  modport slave (
    output waitrequest, readdata, readdatavalid,
    input  burstcount, writedata, address, write, read, byteenable
  );
endinterface

// File: rtl/avalon_mem_burst_splitter.sv
// Avalon-MM burst splitter between an AFU local-memory port and an FIU port
// with a smaller maximum burst. Long read bursts are cut into FIU-legal
// chunks while the AFU read is held off; write bursts pass beat by beat with
// a new FIU sub-burst header inserted every FMAX beats. Read data returns
// combinationally and in order.
// Optional: define AVALON_MEM_BURST_SPLITTER_ALIGN_EN to keep every FIU
// sub-burst inside one FMAX-aligned block of lines.
module avalon_mem_burst_splitter #(
  parameter int ADDR_WIDTH          = 27,
  parameter int DATA_WIDTH          = 512,
  parameter int AFU_BURST_CNT_WIDTH = 7,
  parameter int FIU_BURST_CNT_WIDTH = 3
) (
  input  logic clk,
  input  logic reset,
  avalon_mem_burst_splitter_if.slave  afu,
  avalon_mem_burst_splitter_if.master fiu
);

  localparam int CW   = AFU_BURST_CNT_WIDTH;
  localparam int FMAX = 1 << (FIU_BURST_CNT_WIDTH - 1);
`ifdef AVALON_MEM_BURST_SPLITTER_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_BURST} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         rd_rem;
  logic [ADDR_WIDTH-1:0] wr_addr;       // start address of the next write sub-burst
  logic [CW-1:0]         wr_rem_total;
  logic [CW-1:0]         wr_sub_rem;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CW-1:0]         cur_len;
  logic                  fiu_rd;
  logic                  fiu_wr;
  logic                  afu_wait;

  // Length of the next FIU chunk given the lines left and its start address.
  // With alignment the chunk stops at the next FMAX-aligned boundary.
  function automatic logic [CW-1:0] chunk_len(input logic [CW-1:0] rem,
                                              input logic [ADDR_WIDTH-1:0] addr);
    int room;
    room = ALIGN_EN ? (FMAX - int'(addr & ADDR_WIDTH'(FMAX - 1))) : FMAX;
    if (int'(rem) < room) return rem;
    return CW'(room);
  endfunction

  // Request steering: pick address/length of the FIU request and the AFU stall.
  always_comb begin
    cur_addr = afu.address;
    cur_len  = chunk_len(afu.burstcount, afu.address);
    fiu_rd   = 1'b0;
    fiu_wr   = 1'b0;
    afu_wait = fiu.waitrequest;
    case (state)
      IDLE: begin
        if (afu.write && afu.burstcount != '0) begin
          fiu_wr = 1'b1;
        end else if (afu.read && afu.burstcount != '0) begin
          fiu_rd = 1'b1;
          // A split read is only consumed when its last chunk is accepted.
          if (cur_len != afu.burstcount) afu_wait = 1'b1;
        end
      end
      RD_SPLIT: begin
        cur_addr = rd_addr;
        cur_len  = chunk_len(rd_rem, rd_addr);
        fiu_rd   = 1'b1;
        afu_wait = fiu.waitrequest || (cur_len != rd_rem);
      end
      WR_BURST: begin
        cur_addr = wr_addr;
        cur_len  = chunk_len(wr_rem_total, wr_addr);
        fiu_wr   = afu.write;
      end
      default: ;
    endcase
    if (reset) begin
      fiu_rd   = 1'b0;
      fiu_wr   = 1'b0;
      afu_wait = 1'b1;
    end
  end

  assign fiu.read          = fiu_rd;
  assign fiu.write         = fiu_wr;
  assign fiu.address       = cur_addr;
  assign fiu.burstcount    = cur_len[FIU_BURST_CNT_WIDTH-1:0];
  assign fiu.writedata     = afu.writedata;
  assign fiu.byteenable    = afu.byteenable;
  assign afu.waitrequest   = afu_wait;
  assign afu.readdata      = fiu.readdata;
  assign afu.readdatavalid = fiu.readdatavalid & ~reset;

  // Burst FSM: tracks outstanding read chunks and write sub-burst boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_addr      <= '0;
      rd_rem       <= '0;
      wr_addr      <= '0;
      wr_rem_total <= '0;
      wr_sub_rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (afu.write && afu.burstcount != '0) begin
            if (!fiu.waitrequest) begin
              wr_rem_total <= afu.burstcount - CW'(1);
              wr_sub_rem   <= cur_len - CW'(1);
              wr_addr      <= afu.address + ADDR_WIDTH'(cur_len);
              if (afu.burstcount != CW'(1)) state <= WR_BURST;
            end
          end else if (afu.read && afu.burstcount != '0 &&
                       cur_len != afu.burstcount && !fiu.waitrequest) begin
            rd_addr <= afu.address + ADDR_WIDTH'(cur_len);
            rd_rem  <= afu.burstcount - cur_len;
            state   <= RD_SPLIT;
          end
        end
        RD_SPLIT: begin
          if (!fiu.waitrequest) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(cur_len);
            rd_rem  <= rd_rem - cur_len;
            if (cur_len == rd_rem) state <= IDLE;
          end
        end
        WR_BURST: begin
          if (afu.write && !fiu.waitrequest) begin
            wr_rem_total <= wr_rem_total - CW'(1);
            if (wr_sub_rem == '0) begin
              wr_sub_rem <= cur_len - CW'(1);
              wr_addr    <= wr_addr + ADDR_WIDTH'(cur_len);
            end else begin
              wr_sub_rem <= wr_sub_rem - CW'(1);
            end
            if (wr_rem_total == CW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RTL_SIMULATION
  // Flag illegal AFU requests; the datapath above simply ignores them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == WR_BURST && afu.read)
        $error("avalon_mem_burst_splitter: afu_read during write burst");
      if (state == IDLE && (afu.read || afu.write) && afu.burstcount == '0)
        $error("avalon_mem_burst_splitter: afu_burstcount of zero");
    end
  end
`endif

endmodule

// File: tb/tb_avalon_mem_burst_splitter.sv
// Directed bench for avalon_mem_burst_splitter: one wide instance for the
// main read/write/reset cases and one 4-bit-address instance for wrap.
module tb_avalon_mem_burst_splitter;
  localparam int AW = 27, DW = 512, ABW = 7, FBW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avalon_mem_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(ABW)) afu ();
  avalon_mem_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(FBW)) fiu ();
  avalon_mem_burst_splitter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BURST_CNT_WIDTH(ABW)) afu2 ();
  avalon_mem_burst_splitter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BURST_CNT_WIDTH(FBW)) fiu2 ();

  avalon_mem_burst_splitter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .AFU_BURST_CNT_WIDTH(ABW), .FIU_BURST_CNT_WIDTH(FBW)) dut (
    .clk(clk), .reset(reset), .afu(afu), .fiu(fiu));

  avalon_mem_burst_splitter #(.ADDR_WIDTH(4), .DATA_WIDTH(32),
    .AFU_BURST_CNT_WIDTH(ABW), .FIU_BURST_CNT_WIDTH(FBW)) dut_wrap (
    .clk(clk), .reset(reset), .afu(afu2), .fiu(fiu2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIU-side observation, sampled on the falling edge.
  logic [AW-1:0] rq_addr[$];
  int            rq_cnt[$];
  logic [AW-1:0] wh_addr[$];
  int            wh_cnt[$];
  logic [DW-1:0] wd_q[$];
  logic [DW/8-1:0] wb_q[$];
  logic [3:0]    r2_addr[$];
  int            r2_cnt[$];
  int w_rem = 0, afu_rd_acc = 0, afu_wr_acc = 0, fiu_at_acc = 0, forced = 0;

  always @(negedge clk) begin
    if (fiu.read && !fiu.waitrequest) begin
      rq_addr.push_back(fiu.address);
      rq_cnt.push_back(int'(fiu.burstcount));
    end
    if (fiu.write && !fiu.waitrequest) begin
      if (w_rem == 0) begin
        wh_addr.push_back(fiu.address);
        wh_cnt.push_back(int'(fiu.burstcount));
        w_rem = int'(fiu.burstcount) - 1;
      end else begin
        w_rem--;
      end
      wd_q.push_back(fiu.writedata);
      wb_q.push_back(fiu.byteenable);
    end
    if (afu.read && !afu.waitrequest) begin
      afu_rd_acc++;
      fiu_at_acc = rq_addr.size();
    end
    if (afu.write && !afu.waitrequest) afu_wr_acc++;
    if (afu.read && (afu.waitrequest !== fiu.waitrequest)) forced++;
    if (fiu2.read && !fiu2.waitrequest) begin
      r2_addr.push_back(fiu2.address);
      r2_cnt.push_back(int'(fiu2.burstcount));
    end
  end

  task automatic clear_mon();
    rq_addr.delete(); rq_cnt.delete(); wh_addr.delete(); wh_cnt.delete();
    wd_q.delete(); wb_q.delete(); r2_addr.delete(); r2_cnt.delete();
    w_rem = 0; afu_rd_acc = 0; afu_wr_acc = 0; fiu_at_acc = 0; forced = 0;
  endtask

  function automatic logic [DW-1:0] wdat(input int b);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(b);
    return {16{w}};
  endfunction

  function automatic logic [DW/8-1:0] wbe(input int b);
    logic [7:0] v;
    v = 8'(b * 37 + 5);
    return {8{v}};
  endfunction

  task automatic do_read(input logic [AW-1:0] a, input int n);
    bit acc = 1'b0;
    @(posedge clk); #1;
    afu.read = 1'b1; afu.address = a; afu.burstcount = ABW'(n);
    for (int i = 0; i < 64 && !acc; i++) begin
      fiu.waitrequest = (i % 3 == 0);
      @(negedge clk);
      acc = afu.read && !afu.waitrequest;
      @(posedge clk); #1;
    end
    afu.read = 1'b0; fiu.waitrequest = 1'b0;
    check_val("rd_accept", acc, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int n);
    bit acc;
    for (int b = 0; b < n; b++) begin
      @(posedge clk); #1;
      afu.write = 1'b1; afu.address = a; afu.burstcount = ABW'(n);
      afu.writedata = wdat(b); afu.byteenable = wbe(b);
      acc = 1'b0;
      for (int i = 0; i < 64 && !acc; i++) begin
        fiu.waitrequest = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = afu.write && !afu.waitrequest;
        if (!acc) begin @(posedge clk); #1; end
      end
      check_val("wr_beat_accept", acc, 1);
    end
    @(posedge clk); #1;
    afu.write = 1'b0; fiu.waitrequest = 1'b0;
  endtask

  task automatic return_beats(input int n, input logic [31:0] base);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      w = base + 32'(i);
      fiu.readdatavalid = 1'b1; fiu.readdata = {16{w}};
      @(negedge clk);
      check_val("rdv", afu.readdatavalid, 1);
      check_val("rdata", afu.readdata, {16{w}});
    end
    @(posedge clk); #1;
    fiu.readdatavalid = 1'b0;
  endtask

  task automatic check_rq(input string tag, input int ne,
                          input int a0, input int c0, input int a1, input int c1,
                          input int a2, input int c2);
    int ea[3], ec[3];
    ea[0] = a0; ea[1] = a1; ea[2] = a2;
    ec[0] = c0; ec[1] = c1; ec[2] = c2;
    check_val({tag, "_nreq"}, rq_addr.size(), ne);
    for (int i = 0; i < ne && i < rq_addr.size(); i++) begin
      check_val({tag, "_addr"}, rq_addr[i], ea[i]);
      check_val({tag, "_cnt"}, rq_cnt[i], ec[i]);
    end
  endtask

  initial begin
    afu.read = 1'b1; afu.write = 1'b1; afu.address = '0; afu.burstcount = 7'd4;
    afu.writedata = '0; afu.byteenable = '0;
    fiu.waitrequest = 1'b0; fiu.readdatavalid = 1'b1; fiu.readdata = '0;
    afu2.read = 1'b0; afu2.write = 1'b0; afu2.address = '0; afu2.burstcount = '0;
    afu2.writedata = '0; afu2.byteenable = '0;
    fiu2.waitrequest = 1'b0; fiu2.readdatavalid = 1'b0; fiu2.readdata = '0;
    reset = 1'b1;

    // Reset holds requests off even with AFU requests present.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_fiu_read", fiu.read, 0);
    check_val("rst_fiu_write", fiu.write, 0);
    check_val("rst_afu_wait", afu.waitrequest, 1);
    check_val("rst_afu_rdv", afu.readdatavalid, 0);
    @(posedge clk); #1;
    afu.read = 1'b0; afu.write = 1'b0; fiu.readdatavalid = 1'b0; reset = 1'b0;

    // Short read passes straight through.
    clear_mon();
    do_read(AW'(32'h10), 3);
    check_rq("rd3", 1, 'h10, 3, 0, 0, 0, 0);
    check_val("rd3_forced", forced, 0);
    check_val("rd3_afu_acc", afu_rd_acc, 1);
    return_beats(3, 32'hA000_0000);

    // Long read split into three chunks, AFU held until the last one.
    clear_mon();
    do_read(AW'(32'h100), 10);
    check_rq("rd10", 3, 'h100, 4, 'h104, 4, 'h108, 2);
    check_val("rd10_afu_acc", afu_rd_acc, 1);
    check_val("rd10_release_at", fiu_at_acc, 3);
    return_beats(10, 32'hBEEF_0000);

    // Write burst of nine beats under random FIU stalls.
    clear_mon();
    do_write(AW'(32'h20), 9);
    check_val("wr9_nsub", wh_addr.size(), 3);
    if (wh_addr.size() == 3) begin
      check_val("wr9_sub0", {wh_addr[0], 8'(wh_cnt[0])}, {AW'(32'h20), 8'd4});
      check_val("wr9_sub1", {wh_addr[1], 8'(wh_cnt[1])}, {AW'(32'h24), 8'd4});
      check_val("wr9_sub2", {wh_addr[2], 8'(wh_cnt[2])}, {AW'(32'h28), 8'd1});
    end
    check_val("wr9_nbeats", wd_q.size(), 9);
    for (int b = 0; b < 9 && b < wd_q.size(); b++) begin
      check_val("wr9_data", wd_q[b], wdat(b));
      check_val("wr9_be", wb_q[b], wbe(b));
    end
    check_val("wr9_afu_acc", afu_wr_acc, 9);

    // Unaligned read: chunking depends on the alignment option.
    clear_mon();
    do_read(AW'(32'h3), 6);
`ifdef AVALON_MEM_BURST_SPLITTER_ALIGN_EN
    check_rq("rd6u", 3, 'h3, 1, 'h4, 4, 'h8, 1);
`else
    check_rq("rd6u", 2, 'h3, 4, 'h7, 2, 0, 0);
`endif

    // Reset in the middle of a split read abandons it.
    clear_mon();
    @(posedge clk); #1;
    afu.read = 1'b1; afu.address = AW'(32'h200); afu.burstcount = 7'd10;
    fiu.waitrequest = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; fiu.readdatavalid = 1'b1; fiu.readdata = {16{32'h5A5A_0001}};
    @(negedge clk);
    check_val("mid_rst_fiu_read", fiu.read, 0);
    check_val("mid_rst_afu_wait", afu.waitrequest, 1);
    check_val("mid_rst_rdv", afu.readdatavalid, 0);
    @(posedge clk); #1;
    reset = 1'b0; afu.read = 1'b0;
    @(negedge clk);
    check_val("post_rst_fiu_read", fiu.read, 0);
    check_val("post_rst_rdv", afu.readdatavalid, 1);
    check_val("post_rst_rdata", afu.readdata, {16{32'h5A5A_0001}});
    check_rq("pre_rst", 1, 'h200, 4, 0, 0, 0, 0);
    @(posedge clk); #1;
    fiu.readdatavalid = 1'b0;
    clear_mon();
    do_read(AW'(32'h300), 2);
    check_rq("rd2_after_rst", 1, 'h300, 2, 0, 0, 0, 0);

    // Address wrap on the narrow-address instance.
    clear_mon();
    begin
      bit acc2 = 1'b0;
      @(posedge clk); #1;
      afu2.read = 1'b1; afu2.address = 4'hE; afu2.burstcount = 7'd6;
      for (int i = 0; i < 16 && !acc2; i++) begin
        @(negedge clk);
        acc2 = afu2.read && !afu2.waitrequest;
        @(posedge clk); #1;
      end
      afu2.read = 1'b0;
      check_val("wrap_accept", acc2, 1);
    end
    check_val("wrap_nreq", r2_addr.size(), 2);
    if (r2_addr.size() == 2) begin
`ifdef AVALON_MEM_BURST_SPLITTER_ALIGN_EN
      check_val("wrap_req0", {r2_addr[0], 8'(r2_cnt[0])}, {4'hE, 8'd2});
      check_val("wrap_req1", {r2_addr[1], 8'(r2_cnt[1])}, {4'h0, 8'd4});
`else
      check_val("wrap_req0", {r2_addr[0], 8'(r2_cnt[0])}, {4'hE, 8'd4});
      check_val("wrap_req1", {r2_addr[1], 8'(r2_cnt[1])}, {4'h2, 8'd2});
`endif
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
